// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the target (and the initiator).
// Contents: target FSM state type, ACK/NACK bit levels, R/W bit levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } tgt_state_e;

  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Input synchroniser plus edge detector for one bus line.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   d_i           : raw asynchronous bus line
//   q_o           : synchronised level
//   rise_o/fall_o : single-cycle edge flags on the synchronised level
// Flops reset to 1 (idle bus level) so no false edge appears after reset.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/i2c_target.sv
// Oversampled I2C/SCCB target. Matches a 7-bit address, ACKs writes and
// strobes each received data byte out; on reads it shifts out bytes
// requested from the user logic.
// Ports:
//   clk_i, reset_n_i : system clock (>= 20x SCL), async active-low reset
//   scl_i, sda_io    : bus clock in, open-drain bus data (drives 0 or z)
//   rd_data_i        : next read byte, sampled while rd_req_o is high
//   rx_data_o        : last received write byte
//   rx_valid_o       : strobe, rx_data_o updated
//   rx_first_o       : with rx_valid_o, first data byte after the address
//   rd_req_o         : strobe, next read byte needed
//   busy_o           : addressed, until STOP
//   stop_o           : strobe on STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       scl_i,
  inout  wire        sda_io,
  input  logic [7:0] rd_data_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_first_o,
  output logic       rd_req_o,
  output logic       busy_o,
  output logic       stop_o
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk_i (clk_i), .rst_ni (reset_n_i), .d_i (scl_i),
    .q_o (scl_s), .rise_o (scl_rise), .fall_o (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk_i (clk_i), .rst_ni (reset_n_i), .d_i (sda_io),
    .q_o (sda_s), .rise_o (sda_rise), .fall_o (sda_fall)
  );

  tgt_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       first_q, first_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       rd_req_q, rd_req_d;
  logic       busy_q, busy_d;
  logic       stop_q, stop_d;

  // SCL must have been high on the previous cycle too; an SDA edge that
  // coincides with an SCL edge is a data-bit change, not a bus condition.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl_s & ~scl_rise;
  assign stop_det  = sda_rise & scl_s & ~scl_rise;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd7;
      shift_q    <= '0;
      rw_q       <= I2C_WRITE;
      first_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
      stop_q     <= stop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    // The read byte is captured while rd_req_o is high, so user logic may
    // answer the request combinationally. The next SCL fall is far away.
    shift_d    = rd_req_q ? rd_data_i : shift_q;
    rw_d       = rw_q;
    first_d    = first_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_first_d = 1'b0;
    rd_req_d   = 1'b0;
    busy_d     = busy_q;
    stop_d     = 1'b0;

    if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 3'd7;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = 3'd7;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (cnt_q == 3'd0) begin
              cnt_d = 3'd7;
              if (shift_q[6:0] == DEVICE_ADDR) begin
                busy_d  = 1'b1;
                rw_d    = sda_s;
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end

        // First fall: pull SDA low for the ACK. Second fall: end of ACK clock.
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              if (state_q == ST_ADDR_ACK && rw_q == I2C_READ) rd_req_d = 1'b1;
            end else if (state_q == ST_ADDR_ACK && rw_q == I2C_READ) begin
              // The fall ending the ACK clock is where read bit 7 goes out.
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              state_d  = ST_RD_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == ST_ADDR_ACK) first_d = 1'b1;
              state_d  = ST_WR_BYTE;
            end
          end
        end

        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (cnt_q == 3'd0) begin
              cnt_d      = 3'd7;
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
              state_d    = ST_WR_ACK;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end

        // Falls present bits, rises count them. After the 8th rise the next
        // fall (handled in RD_ACK) releases SDA for the initiator's ACK.
        ST_RD_BYTE: begin
          if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
          end else if (scl_rise) begin
            if (cnt_q == 3'd0) begin
              cnt_d   = 3'd7;
              state_d = ST_RD_ACK;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              rd_req_d = 1'b1;
              state_d  = ST_RD_BYTE;
            end else begin
              state_d  = ST_IGNORE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign sda_io     = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_first_o = rx_first_q;
  assign rd_req_o   = rd_req_q;
  assign busy_o     = busy_q;
  assign stop_o     = stop_q;

endmodule

// File: tb/tb_i2c_target.sv
// Testbench for i2c_target: bus-level initiator tasks, an rx scoreboard
// fed by the stimulus and drained by a monitor, and directed checks.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] rd_data = 8'h00;
  wire        sda_w;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first, rd_req, busy, stop;

  pullup (sda_w);
  assign sda_w = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target #(.DEVICE_ADDR(7'h21), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .scl_i      (scl),
    .sda_io     (sda_w),
    .rd_data_i  (rd_data),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_first_o (rx_first),
    .rd_req_o   (rd_req),
    .busy_o     (busy),
    .stop_o     (stop)
  );

  int n_tests = 0;
  int n_fail = 0;
  int stop_cnt = 0;
  int rd_cnt = 0;
  logic [8:0] exp_q[$];   // {first, data}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: drains the rx scoreboard and counts strobes.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rx_unexpected: got data 0x%0h first %0b, expected no strobe", rx_data, rx_first);
        end else begin
          e = exp_q.pop_front();
          if ({rx_first, rx_data} !== e) begin
            n_fail++;
            $display("FAIL rx_byte: got first %0b data 0x%0h, expected first %0b data 0x%0h",
                     rx_first, rx_data, e[8], e[7:0]);
          end
        end
      end
      if (stop) stop_cnt++;
      if (rd_req) rd_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One SCL clock: set SDA while low, sample mid-high, leave SCL low.
  task automatic clk_bit(input logic b, output logic s);
    m_low = ~b;
    #T;
    scl = 1'b1;
    #(T/2);
    s = sda_w;
    #(T/2);
    scl = 1'b0;
    #(T/2);
  endtask

  task automatic start_c();
    m_low = 1'b0;
    #T;
    scl = 1'b1;
    #T;
    m_low = 1'b1;
    #T;
    scl = 1'b0;
    #T;
  endtask

  task automatic stop_c();
    m_low = 1'b1;
    #T;
    scl = 1'b1;
    #T;
    m_low = 1'b0;
    #T;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic [7:0] next, input logic ackb, output logic [7:0] d);
    logic s;
    logic [7:0] v;
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      v[i] = s;
    end
    rd_data = next;
    clk_bit(ackb, s);
    d = v;
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    logic [7:0] v42;
    int         sc, rc;
    v42 = 8'h42;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("reset_outputs", {rx_data, rx_valid, rx_first, rd_req, busy, stop}, 0);
    chk("reset_sda", sda_w, 1);
    reset_n = 1'b1;
    #T;

    // Write 0x42, 0x12, 0x80, STOP
    sc = stop_cnt;
    start_c();
    write_byte(8'h42, ack);
    chk("t1_addr_ack", ack, I2C_ACK);
    chk("t1_busy", busy, 1);
    exp_q.push_back({1'b1, 8'h12});
    write_byte(8'h12, ack);
    chk("t1_data0_ack", ack, I2C_ACK);
    exp_q.push_back({1'b0, 8'h80});
    write_byte(8'h80, ack);
    chk("t1_data1_ack", ack, I2C_ACK);
    stop_c();
    #T;
    chk("t1_stop_pulses", stop_cnt - sc, 1);
    chk("t1_busy_clr", busy, 0);
    chk("t1_rx_drained", exp_q.size(), 0);

    // Mismatched address 0x60
    start_c();
    write_byte(8'h60, ack);
    chk("t2_addr_nack", ack, I2C_NACK);
    chk("t2_busy", busy, 0);
    write_byte(8'h12, ack);
    chk("t2_data_nack", ack, I2C_NACK);
    stop_c();
    #T;

    // Read 0xA5 (ACK) then 0x3C (NACK)
    rd_data = 8'hA5;
    rc = rd_cnt;
    start_c();
    write_byte(8'h43, ack);
    chk("t3_addr_ack", ack, I2C_ACK);
    read_byte(8'h3C, I2C_ACK, d);
    chk("t3_rd0", d, 8'hA5);
    read_byte(8'h00, I2C_NACK, d);
    chk("t3_rd1", d, 8'h3C);
    #T;
    chk("t3_rd_req_pulses", rd_cnt - rc, 2);
    chk("t3_sda_released", sda_w, 1);
    stop_c();
    #T;

    // Write 0x0A, repeated START, read 0x77
    start_c();
    write_byte(8'h42, ack);
    chk("t4_addr_ack", ack, I2C_ACK);
    exp_q.push_back({1'b1, 8'h0A});
    write_byte(8'h0A, ack);
    chk("t4_data_ack", ack, I2C_ACK);
    rd_data = 8'h77;
    start_c();
    write_byte(8'h43, ack);
    chk("t4_rs_addr_ack", ack, I2C_ACK);
    read_byte(8'h00, I2C_NACK, d);
    chk("t4_rd", d, 8'h77);
    stop_c();
    #T;
    chk("t4_rx_drained", exp_q.size(), 0);

    // STOP after 4 data bits, then a normal write
    start_c();
    write_byte(8'h42, ack);
    chk("t5_addr_ack", ack, I2C_ACK);
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    clk_bit(1'b1, s);
    clk_bit(1'b1, s);
    stop_c();
    #T;
    chk("t5_busy_clr", busy, 0);
    start_c();
    write_byte(8'h42, ack);
    chk("t5_next_addr_ack", ack, I2C_ACK);
    exp_q.push_back({1'b1, 8'h5A});
    write_byte(8'h5A, ack);
    chk("t5_next_data_ack", ack, I2C_ACK);
    stop_c();
    #T;
    chk("t5_rx_drained", exp_q.size(), 0);

    // Reset while the target holds the ACK low
    start_c();
    for (int i = 7; i >= 0; i--) clk_bit(v42[i], s);
    m_low = 1'b0;
    #T;
    chk("t6_ack_driven", sda_w, 0);
    chk("t6_busy", busy, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_sda_released", sda_w, 1);
    chk("t6_outputs_zero", {rx_data, rx_valid, rx_first, rd_req, busy, stop}, 0);
    scl = 1'b1;
    #T;
    reset_n = 1'b1;
    #T;
    start_c();
    write_byte(8'h42, ack);
    chk("t6_post_reset_ack", ack, I2C_ACK);
    exp_q.push_back({1'b1, 8'h99});
    write_byte(8'h99, ack);
    chk("t6_post_reset_data_ack", ack, I2C_ACK);
    stop_c();
    #(2*T);
    chk("t6_rx_drained", exp_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
